// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the unified memory between the core and the loader.
// Each access runs issue, read-latency wait and a single-cycle ack.
module mem_port_arbiter #(
    parameter int AW     = 32,
    parameter int DW     = 32,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_rdata,
    input  logic          ld_req,
    input  logic          ld_we,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_wdata,
    output logic          ld_ack,
    output logic [DW-1:0] ld_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          owner
);

    localparam int CW = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic          owner_q;
    logic          mem_en_q;
    logic          mem_we_q;
    logic [AW-1:0] mem_addr_q;
    logic [DW-1:0] mem_wdata_q;
    logic          cpu_ack_q;
    logic          ld_ack_q;
    logic [DW-1:0] cpu_rdata_q;
    logic [DW-1:0] ld_rdata_q;

    logic          gnt_vld;
    logic          gnt_sel_d;
    logic          gnt_we_d;
    logic [AW-1:0] gnt_addr_d;
    logic [DW-1:0] gnt_wdata_d;

    // On a tie the requester that did not own the last access wins.
    always_comb begin
        gnt_vld   = cpu_req | ld_req;
        gnt_sel_d = 1'b0;
        if (cpu_req && ld_req) begin
            gnt_sel_d = ~owner_q;
        end else if (ld_req) begin
            gnt_sel_d = 1'b1;
        end
        gnt_we_d    = gnt_sel_d ? ld_we    : cpu_we;
        gnt_addr_d  = gnt_sel_d ? ld_addr  : cpu_addr;
        gnt_wdata_d = gnt_sel_d ? ld_wdata : cpu_wdata;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            owner_q     <= 1'b1;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_ack_q   <= 1'b0;
            ld_ack_q    <= 1'b0;
            cpu_rdata_q <= '0;
            ld_rdata_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (gnt_vld) begin
                        owner_q     <= gnt_sel_d;
                        mem_en_q    <= 1'b1;
                        mem_we_q    <= gnt_we_d;
                        mem_addr_q  <= gnt_addr_d;
                        mem_wdata_q <= gnt_wdata_d;
                        state_q     <= ISSUE;
                    end
                end
                ISSUE: begin
                    mem_en_q <= 1'b0;
                    if (mem_we_q) begin
                        cpu_ack_q <= ~owner_q;
                        ld_ack_q  <= owner_q;
                        state_q   <= DONE;
                    end else begin
                        cnt_q   <= CW'(RD_LAT);
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_q == CW'(1)) begin
                        if (owner_q) begin
                            ld_rdata_q <= mem_rdata;
                        end else begin
                            cpu_rdata_q <= mem_rdata;
                        end
                        cpu_ack_q <= ~owner_q;
                        ld_ack_q  <= owner_q;
                        cnt_q     <= '0;
                        state_q   <= DONE;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                DONE: begin
                    cpu_ack_q <= 1'b0;
                    ld_ack_q  <= 1'b0;
                    state_q   <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign cpu_ack   = cpu_ack_q;
    assign cpu_rdata = cpu_rdata_q;
    assign ld_ack    = ld_ack_q;
    assign ld_rdata  = ld_rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign owner     = owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vectors, corner sequences and a randomized
// run against a transaction-level model of the shared memory port.
module tb_mem_port_arbiter;

    localparam int L  = 1;
    localparam int L4 = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, ld_req, ld_we;
    logic [31:0] cpu_addr, cpu_wdata, ld_addr, ld_wdata;
    logic        cpu_ack, ld_ack, mem_en, mem_we, owner;
    logic [31:0] cpu_rdata, ld_rdata, mem_addr, mem_wdata, mem_rdata;

    logic        c4_req, c4_we, l4_req, l4_we;
    logic [31:0] c4_addr, c4_wdata, l4_addr, l4_wdata;
    logic        c4_ack, l4_ack, en4, we4, owner4;
    logic [31:0] c4_rdata, l4_rdata, addr4, wdata4, rdata4;

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(32), .DW(32), .RD_LAT(L)) u_dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr),
        .ld_wdata(ld_wdata), .ld_ack(ld_ack), .ld_rdata(ld_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .owner(owner)
    );

    mem_port_arbiter #(.AW(32), .DW(32), .RD_LAT(L4)) u_dut4 (
        .clk(clk), .reset(reset),
        .cpu_req(c4_req), .cpu_we(c4_we), .cpu_addr(c4_addr),
        .cpu_wdata(c4_wdata), .cpu_ack(c4_ack), .cpu_rdata(c4_rdata),
        .ld_req(l4_req), .ld_we(l4_we), .ld_addr(l4_addr),
        .ld_wdata(l4_wdata), .ld_ack(l4_ack), .ld_rdata(l4_rdata),
        .mem_en(en4), .mem_we(we4), .mem_addr(addr4),
        .mem_wdata(wdata4), .mem_rdata(rdata4), .owner(owner4)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model driven purely from the DUT memory pins.
    logic [31:0] bmem [64];
    logic [31:0] sched [int];

    always @(negedge clk) begin
        if (mem_en) begin
            if (mem_we) bmem[mem_addr[7:2]] = mem_wdata;
            else sched[cyc + L] = bmem[mem_addr[7:2]];
        end
    end

    always @(posedge clk) begin
        #1;
        if (sched.exists(cyc)) begin
            mem_rdata = sched[cyc];
            sched.delete(cyc);
        end else begin
            mem_rdata = $urandom;
        end
        rdata4 = {16'hA5A5, cyc[15:0]};
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    typedef struct {
        bit          who;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          pre;
        logic [31:0] memval;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t tbl [6];

    task automatic run_vec(input vec_t v);
        int lat;
        int ens;
        int acks;
        logic own_ack, oth_ack;
        logic [31:0] own_rd;
        lat  = v.we ? 2 : 2 + L;
        ens  = 0;
        acks = 0;
        if (v.pre) bmem[v.addr[7:2]] = v.memval;
        cpu_req = !v.who; cpu_we = v.we; cpu_addr = v.addr; cpu_wdata = v.wdata;
        ld_req  = v.who;  ld_we  = v.we; ld_addr  = v.addr; ld_wdata  = v.wdata;
        for (int k = 0; k <= lat; k++) begin
            if (k > 0) step();
            sample();
            own_ack = v.who ? ld_ack : cpu_ack;
            oth_ack = v.who ? cpu_ack : ld_ack;
            own_rd  = v.who ? ld_rdata : cpu_rdata;
            ens  += int'(mem_en);
            acks += int'(own_ack);
            chk("vec_other_ack", oth_ack, 1'b0);
            if (k == 1) begin
                chk("vec_issue_en", mem_en, 1'b1);
                chk("vec_issue_we", mem_we, v.we);
                chk("vec_issue_addr", mem_addr, v.addr);
                if (v.we) chk("vec_issue_wdata", mem_wdata, v.wdata);
            end
            if (k == lat) begin
                chk("vec_ack_time", own_ack, 1'b1);
                chk("vec_rdata", own_rd, v.exp_rdata);
            end
        end
        chk("vec_en_count", ens, 1);
        chk("vec_ack_count", acks, 1);
        step();
        cpu_req = 1'b0;
        ld_req  = 1'b0;
        step();
    endtask

    task automatic do_reset();
        reset   = 1'b0;
        cpu_req = 1'b0;
        ld_req  = 1'b0;
        repeat (2) step();
        reset = 1'b1;
    endtask

    // Randomized-phase reference state.
    logic        rq [2];
    logic        rwe [2];
    logic [31:0] raddr [2];
    logic [31:0] rwd [2];
    bit          pend [2];
    bit          infl [2];
    bit          ackseen [2];
    logic [31:0] refmem [64];
    bit          busy;
    int          c, exp_issue, exp_ack, gw;
    logic        g_we;
    logic [31:0] g_addr, g_wd, g_data;
    logic        e_owner, e_we;
    logic [31:0] e_addr, e_wd, e_crd, e_lrd;
    logic        e_en, e_cack, e_lack;

    int   fq [$];
    logic pc, pl;
    int   n_en, n_ack, n_lack, k_en, k_ack, t0;
    logic [31:0] e4;

    initial begin
        reset = 1'b0;
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        ld_req = 0; ld_we = 0; ld_addr = 0; ld_wdata = 0;
        c4_req = 0; c4_we = 0; c4_addr = 0; c4_wdata = 0;
        l4_req = 0; l4_we = 0; l4_addr = 0; l4_wdata = 0;
        for (int i = 0; i < 64; i++) bmem[i] = 32'h0;

        repeat (2) sample();
        chk("rst_mem_en", mem_en, 1'b0);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_acks", {cpu_ack, ld_ack}, 2'b00);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_rdata", {cpu_rdata, ld_rdata}, 64'h0);
        chk("rst_owner", owner, 1'b1);

        // Both requesters hold writes continuously from reset release.
        step();
        reset = 1'b1;
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'h0; cpu_wdata = 32'h1;
        ld_req  = 1; ld_we  = 1; ld_addr  = 32'h4; ld_wdata  = 32'h2;
        pc = 0; pl = 0;
        for (int k = 0; k < 14; k++) begin
            if (k > 0) step();
            sample();
            chk("fair_no_dual_ack", cpu_ack & ld_ack, 1'b0);
            chk("fair_pulse", (cpu_ack & pc) | (ld_ack & pl), 1'b0);
            if (cpu_ack) begin
                fq.push_back(0);
                chk("fair_owner_core", owner, 1'b0);
            end
            if (ld_ack) begin
                fq.push_back(1);
                chk("fair_owner_ld", owner, 1'b1);
            end
            pc = cpu_ack;
            pl = ld_ack;
        end
        chk("fair_ack_total", fq.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk("fair_order", (i < fq.size()) ? fq[i] : -1, i % 2);
        end
        step();
        cpu_req = 0;
        ld_req  = 0;
        repeat (6) step();

        tbl[0] = '{0, 0, 32'h10, 32'h0, 1, 32'hDEADBEEF, 32'hDEADBEEF};
        tbl[1] = '{1, 1, 32'h20, 32'h12345678, 0, 32'h0, 32'h0};
        tbl[2] = '{1, 0, 32'h20, 32'h0, 0, 32'h0, 32'h12345678};
        tbl[3] = '{0, 1, 32'h10, 32'hCAFEF00D, 0, 32'h0, 32'hDEADBEEF};
        tbl[4] = '{0, 0, 32'h10, 32'h0, 0, 32'h0, 32'hCAFEF00D};
        tbl[5] = '{1, 0, 32'h44, 32'h0, 1, 32'hA5A55A5A, 32'hA5A55A5A};
        for (int i = 0; i < 6; i++) run_vec(tbl[i]);

        // Randomized traffic against the transaction-level model.
        for (int i = 0; i < 64; i++) begin
            bmem[i]   = (i * 32'h01010101) ^ 32'hC0DE0000;
            refmem[i] = (i * 32'h01010101) ^ 32'hC0DE0000;
        end
        do_reset();
        busy = 0; e_owner = 1; e_we = 0; e_addr = 0; e_wd = 0;
        e_crd = 0; e_lrd = 0;
        for (int r = 0; r < 2; r++) begin
            pend[r] = 0; infl[r] = 0; ackseen[r] = 0; rq[r] = 0;
            rwe[r] = 0; raddr[r] = 0; rwd[r] = 0;
        end
        for (int n = 0; n < 2500; n++) begin
            if (n > 0) step();
            c = cyc;
            for (int r = 0; r < 2; r++) begin
                if (ackseen[r]) begin
                    pend[r] = 0;
                    infl[r] = 0;
                end
                ackseen[r] = 0;
                if (infl[r]) begin
                    rq[r]    = 1'($urandom);
                    rwe[r]   = 1'($urandom);
                    raddr[r] = $urandom & 32'hFC;
                    rwd[r]   = $urandom;
                end else if (!pend[r]) begin
                    pend[r]  = ($urandom_range(99) < 45);
                    rq[r]    = pend[r];
                    rwe[r]   = 1'($urandom);
                    raddr[r] = $urandom & 32'hFC;
                    rwd[r]   = $urandom;
                end
            end
            cpu_req = rq[0]; cpu_we = rwe[0];
            cpu_addr = raddr[0]; cpu_wdata = rwd[0];
            ld_req = rq[1]; ld_we = rwe[1];
            ld_addr = raddr[1]; ld_wdata = rwd[1];
            if (!busy && (rq[0] || rq[1])) begin
                gw = (rq[0] && rq[1]) ? int'(!e_owner) : int'(rq[1]);
                busy = 1;
                g_we = rwe[gw];
                g_addr = raddr[gw];
                g_wd = rwd[gw];
                exp_issue = c + 1;
                exp_ack = c + 2 + (g_we ? 0 : L);
                if (g_we) refmem[g_addr[7:2]] = g_wd;
                else g_data = refmem[g_addr[7:2]];
                pend[gw] = 0;
                infl[gw] = 1;
            end
            sample();
            e_en = busy && (c == exp_issue);
            if (e_en) begin
                e_owner = gw[0];
                e_we = g_we;
                e_addr = g_addr;
                e_wd = g_wd;
            end
            e_cack = busy && (c == exp_ack) && (gw == 0);
            e_lack = busy && (c == exp_ack) && (gw == 1);
            if (busy && (c == exp_ack) && !g_we) begin
                if (gw == 0) e_crd = g_data;
                else e_lrd = g_data;
            end
            chk("rnd_mem_en", mem_en, e_en);
            chk("rnd_mem_we", mem_we, e_we);
            chk("rnd_mem_addr", mem_addr, e_addr);
            chk("rnd_mem_wdata", mem_wdata, e_wd);
            chk("rnd_cpu_ack", cpu_ack, e_cack);
            chk("rnd_ld_ack", ld_ack, e_lack);
            chk("rnd_cpu_rdata", cpu_rdata, e_crd);
            chk("rnd_ld_rdata", ld_rdata, e_lrd);
            chk("rnd_owner", owner, e_owner);
            if (busy && (c == exp_ack)) begin
                busy = 0;
                ackseen[gw] = 1;
            end
        end
        step();
        cpu_req = 0;
        ld_req  = 0;
        repeat (8) step();

        // Reset in the WAIT cycle of a core read.
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h30;
        step();
        step();
        #2;
        reset = 1'b0;
        #1;
        chk("rstmid_en_we", {mem_en, mem_we}, 2'b00);
        chk("rstmid_acks", {cpu_ack, ld_ack}, 2'b00);
        chk("rstmid_addr_wdata", {mem_addr, mem_wdata}, 64'h0);
        chk("rstmid_rdata", {cpu_rdata, ld_rdata}, 64'h0);
        chk("rstmid_owner", owner, 1'b1);
        cpu_req = 0;
        repeat (2) step();
        reset = 1'b1;
        n_ack = 0;
        for (int k = 0; k < 6; k++) begin
            sample();
            n_ack += int'(cpu_ack);
            chk("rstmid_owner_hold", owner, 1'b1);
            step();
        end
        chk("rstmid_no_ack", n_ack, 0);
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h50;
        ld_req  = 1; ld_we  = 1; ld_addr  = 32'h60; ld_wdata = 32'h77;
        step();
        sample();
        chk("rstmid_tie_en", mem_en, 1'b1);
        chk("rstmid_tie_addr", mem_addr, 32'h50);
        chk("rstmid_tie_owner", owner, 1'b0);
        step();
        cpu_req = 0;
        ld_req  = 0;
        repeat (6) step();

        // Address change during WAIT is ignored.
        bmem[6'h10] = 32'h0BADCAFE;
        bmem[6'h20] = 32'h11111111;
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h40;
        n_en = 0;
        n_ack = 0;
        for (int k = 0; k <= 4; k++) begin
            if (k > 0) step();
            if (k == 2) cpu_addr = 32'h80;
            if (k == 4) cpu_req = 0;
            sample();
            n_en  += int'(mem_en);
            n_ack += int'(cpu_ack);
            if (k == 1) chk("achg_addr", mem_addr, 32'h40);
            if (k == 3) begin
                chk("achg_ack", cpu_ack, 1'b1);
                chk("achg_rdata", cpu_rdata, 32'h0BADCAFE);
            end
        end
        chk("achg_en_count", n_en, 1);
        chk("achg_ack_count", n_ack, 1);
        repeat (4) step();

        // Four-cycle read latency instance.
        c4_req = 1; c4_we = 0; c4_addr = 32'h10;
        t0 = cyc;
        n_en = 0; n_ack = 0; n_lack = 0; k_en = -1; k_ack = -1;
        e4 = {16'hA5A5, 16'(t0 + 5)};
        for (int k = 0; k <= 8; k++) begin
            if (k > 0) step();
            if (k == 7) c4_req = 0;
            sample();
            if (en4) begin
                n_en++;
                k_en = k;
            end
            if (c4_ack) begin
                n_ack++;
                k_ack = k;
                chk("lat4_rdata", c4_rdata, e4);
            end
            n_lack += int'(l4_ack);
        end
        chk("lat4_en_count", n_en, 1);
        chk("lat4_en_cycle", k_en, 1);
        chk("lat4_ack_count", n_ack, 1);
        chk("lat4_ack_cycle", k_ack, 6);
        chk("lat4_ld_ack", n_lack, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified instruction/data memory of the multicycle MIPS core between two requesters.
- Requester 0 is the core, covering FETCH, MEMREAD and MEMWRITE accesses.
- Requester 1 is the program loader/debug port.
- Owns the memory-side pins and sequences each access (issue, read-latency wait, response), using round-robin arbitration on ties. The core's control FSM holds its state until it sees the ack.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- RD_LAT, 1, memory read latency in cycles, legal range 1..8. mem_rdata is valid RD_LAT cycles after the cycle mem_en is high.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- cpu_req  in  1  core access request; held until cpu_ack.
- cpu_we  in  1  1=write, 0=read.
- cpu_addr  in  AW  byte address.
- cpu_wdata  in  DW  write data.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_rdata  out  DW  read data, valid while cpu_ack=1.
- ld_req  in  1  loader request.
- ld_we  in  1  loader write enable.
- ld_addr  in  AW  loader address.
- ld_wdata  in  DW  loader write data.
- ld_ack  out  1  loader completion pulse.
- ld_rdata  out  DW  loader read data, valid while ld_ack=1.
- mem_en  out  1  memory access strobe, one cycle per access.
- mem_we  out  1  memory write enable, qualified by mem_en.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data.
- owner  out  1  current or last owner, 0=core, 1=loader.

Behaviour:
- States: IDLE, ISSUE, WAIT, DONE, held in a 2-bit state register.
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - mem_en, mem_we, cpu_ack, ld_ack = 0.
  - mem_addr, mem_wdata, cpu_rdata, ld_rdata = 0.
  - owner=1, so the core wins the first tie.
  - Wait counter = 0.
- Reset mid-access abandons the access. No ack is produced.
- IDLE, cycle t:
  - Only one req high: grant it.
  - Both high: grant the requester that is not owner (round-robin).
  - Neither high: stay in IDLE.
  - On grant, latch owner, we, addr and wdata of the winner, then go to ISSUE.
- ISSUE, cycle t+1:
  - mem_en=1, mem_we=latched we, mem_addr/mem_wdata = latched values.
  - Write: go to DONE.
  - Read: load counter with RD_LAT and go to WAIT.
- WAIT:
  - mem_en=0; counter decrements each cycle.
  - On the cycle where counter==1, capture mem_rdata into the owner's rdata register and go to DONE.
  - WAIT lasts exactly RD_LAT cycles.
- DONE:
  - The owner's ack=1 for exactly one cycle; the other ack stays 0.
  - Go to IDLE.
- Latency from req sampled in IDLE at cycle t:
  - Write: ack at t+2.
  - Read: ack at t+2+RD_LAT.
- Throughput: at most one access per 3+(read?RD_LAT:0) cycles; no pipelining.
- Input stability: req, we, addr and wdata are sampled only in IDLE. Changes while ISSUE/WAIT/DONE are ignored.
- Dropping req mid-access does not cancel the access; ack still pulses.
- Requester obligation: deassert req in the cycle after ack, or keep it high to request a new access. A req still high when IDLE is re-entered is treated as a new request.
- rdata outputs hold their last captured value until the next read for that requester. Write completions do not modify rdata.
- mem_addr, mem_wdata and mem_we hold their last values when mem_en=0.
- Fairness: with both reqs continuously high, grants alternate core, loader, core, and so on. No starvation.

Test Plan:
- Reset release, core read addr 0x00000010, mem returns 0xDEADBEEF, RD_LAT=1.
  -> mem_en high at t+1 with mem_addr=0x10, mem_we=0.
  -> cpu_ack at t+3 with cpu_rdata=0xDEADBEEF; ld_ack stays 0.
- Loader write addr 0x20, data 0x12345678.
  -> mem_en=1, mem_we=1, mem_wdata=0x12345678 at t+1.
  -> ld_ack at t+2; ld_rdata unchanged.
- Both reqs high from reset, both holding req continuously.
  -> Grant order core, loader, core, loader; owner toggles; each ack single-cycle.
- RD_LAT=4 build, core read.
  -> Exactly one mem_en pulse; cpu_ack at t+6; data captured from the 4th cycle after ISSUE.
- Assert reset=0 during WAIT of a core read.
  -> Outputs zero immediately; no cpu_ack afterwards.
  -> After release, owner=1 and the next simultaneous request grants the core.
- Core changes cpu_addr from 0x40 to 0x80 during WAIT.
  -> Memory access uses 0x40; a single ack is produced.
